// File: rtl/teclado_varredura.sv
// 4x4 matrix keypad scanner: drives one column at a time, debounces press and release,
// and emits one registered key code with a single-cycle insere strobe per key press.
module teclado_varredura #(
    parameter int unsigned SCAN_DIV        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] linhas,
    output logic [3:0] colunas,
    output logic [3:0] numero,
    output logic       insere
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_REL} state_t;

    state_t          state, state_n;
    logic [3:0]      sync1, ls;
    logic [DW-1:0]   div, div_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      row, row_n;
    logic [1:0]      col, col_n;
    logic [3:0]      colunas_n, numero_n;
    logic            insere_n;
    logic            row_bit;
    logic [1:0]      first_row;

    assign row_bit = ls[row];

    // Lowest-index active row wins when several rows are sensed together.
    always_comb begin
        first_row = 2'd3;
        if (ls[0])      first_row = 2'd0;
        else if (ls[1]) first_row = 2'd1;
        else if (ls[2]) first_row = 2'd2;
    end

    always_comb begin
        state_n   = state;
        div_n     = div;
        cnt_n     = cnt;
        row_n     = row;
        col_n     = col;
        numero_n  = numero;
        insere_n  = 1'b0;
        unique case (state)
            SCAN: begin
                if (div == DW'(SCAN_DIV - 1)) begin
                    div_n = '0;
                    if (ls != '0) begin
                        state_n = DEBOUNCE;
                        cnt_n   = '0;
                        row_n   = first_row;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    div_n = div + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_bit) begin
                    state_n = SCAN;
                    cnt_n   = '0;
                    col_n   = col + 2'd1;
                end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                    state_n  = EMIT;
                    insere_n = 1'b1;
                    numero_n = {row, col};
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            EMIT: begin
                state_n = WAIT_REL;
                cnt_n   = '0;
            end
            WAIT_REL: begin
                if (row_bit) begin
                    cnt_n = '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_n = SCAN;
                    cnt_n   = '0;
                    div_n   = '0;
                    col_n   = col + 2'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
        colunas_n = 4'b0001 << col_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SCAN;
            sync1   <= '0;
            ls      <= '0;
            div     <= '0;
            cnt     <= '0;
            row     <= '0;
            col     <= '0;
            colunas <= 4'b0001;
            numero  <= '0;
            insere  <= 1'b0;
        end else begin
            state   <= state_n;
            sync1   <= linhas;
            ls      <= sync1;
            div     <= div_n;
            cnt     <= cnt_n;
            row     <= row_n;
            col     <= col_n;
            colunas <= colunas_n;
            numero  <= numero_n;
            insere  <= insere_n;
        end
    end

endmodule

// File: tb/tb_teclado_varredura.sv
// Bench for teclado_varredura: keypad model plus a strobe scoreboard of expected key codes.
module tb_teclado_varredura;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] linhas;
    logic [3:0] colunas;
    logic [3:0] numero;
    logic       insere;
    logic [15:0] keys = '0;

    int vectors    = 0;
    int miscompares = 0;
    int strobes    = 0;
    logic [3:0] exp_q[$];
    logic prev_ins = 1'b0;

    typedef struct {
        logic [15:0] keys;
        int unsigned hold;
        logic [3:0]  exp_num;
        logic [3:0]  exp_col;
    } vec_t;
    vec_t tbl[4];

    teclado_varredura #(.SCAN_DIV(3), .DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .linhas  (linhas),
        .colunas (colunas),
        .numero  (numero),
        .insere  (insere)
    );

    always #5 clk = ~clk;

    // Keypad: key index 4*(row-1)+(col-1); a row reads high if any pressed key sits in a driven column.
    always_comb begin
        linhas = '0;
        for (int r = 0; r < 4; r++) linhas[r] = |(keys[4*r +: 4] & colunas);
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (insere === 1'b1) begin
            strobes++;
            check("insere_consecutive", {3'b000, prev_ins}, 4'b0000);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: numero=%b expected no strobe", numero);
            end else begin
                check("strobe_numero", numero, exp_q.pop_front());
            end
        end
        prev_ins = (insere === 1'b1);
    end

    task automatic wait_col_rise(input logic [3:0] target);
        logic [3:0] prev;
        prev = colunas;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (colunas === target && prev !== target) return;
            prev = colunas;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_colunas: got %b expected %b within 60 cycles", colunas, target);
    endtask

    task automatic apply_vec(input vec_t v);
        int s0;
        s0 = strobes;
        exp_q.push_back(v.exp_num);
        keys = v.keys;
        repeat (v.hold) @(posedge clk);
        #1;
        check("held_colunas", colunas, v.exp_col);
        check("held_numero", numero, v.exp_num);
        keys = '0;
        repeat (30) @(posedge clk);
        #1;
        check_int("strobe_count", strobes - s0, 1);
        check_int("queue_drained", exp_q.size(), 0);
        check("colunas_rescan", {3'b000, colunas == v.exp_col}, 4'b0000);
    endtask

    initial begin
        int s0;
        logic [3:0] ec;
        tbl[0] = '{keys: 16'h0200, hold: 40, exp_num: 4'b1001, exp_col: 4'b0010};
        tbl[1] = '{keys: 16'h0020, hold: 40, exp_num: 4'b0101, exp_col: 4'b0010};
        tbl[2] = '{keys: 16'h0200, hold: 40, exp_num: 4'b1001, exp_col: 4'b0010};
        tbl[3] = '{keys: 16'h0001, hold: 40, exp_num: 4'b0000, exp_col: 4'b0001};

        // Idle scan after reset: three cycles per column, two full rotations.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_numero", numero, 4'b0000);
        check("reset_insere", {3'b000, insere}, 4'b0000);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            ec = 4'b0001 << ((k / 3) % 4);
            check("idle_colunas", colunas, ec);
        end
        check_int("idle_strobes", strobes, 0);

        // Glitch on row1/col1 seen by the synchronized rows for only two cycles.
        s0 = strobes;
        wait_col_rise(4'b0001);
        keys = 16'h0001;
        repeat (2) @(posedge clk);
        #1 keys = '0;
        repeat (3) @(posedge clk);
        #1;
        check("glitch_resume_col", colunas, 4'b0010);
        repeat (20) @(posedge clk);
        #1;
        check_int("glitch_strobes", strobes - s0, 0);

        apply_vec(tbl[0]);

        // Rows 2 and 4 in column 4 together, then a short release bounce.
        s0 = strobes;
        exp_q.push_back(4'b0111);
        keys = 16'h8080;
        repeat (40) @(posedge clk);
        #1;
        check("multi_colunas", colunas, 4'b1000);
        check("multi_numero", numero, 4'b0111);
        keys = '0;
        repeat (2) @(posedge clk);
        #1 keys = 16'h8080;
        repeat (2) @(posedge clk);
        #1;
        check("bounce_frozen", colunas, 4'b1000);
        keys = '0;
        repeat (30) @(posedge clk);
        #1;
        check_int("multi_strobes", strobes - s0, 1);
        check_int("multi_queue", exp_q.size(), 0);

        // Reset pulse while debouncing row4/col4 abandons the key.
        s0 = strobes;
        wait_col_rise(4'b1000);
        keys = 16'h8000;
        repeat (4) @(posedge clk);
        #1;
        check("debounce_frozen", colunas, 4'b1000);
        reset = 1'b1;
        keys  = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_colunas", colunas, 4'b0001);
        check("rst_numero", numero, 4'b0000);
        check("rst_insere", {3'b000, insere}, 4'b0000);
        repeat (30) @(posedge clk);
        #1;
        check_int("rst_strobes", strobes - s0, 0);

        for (int i = 1; i < 4; i++) apply_vec(tbl[i]);

        check_int("final_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
